// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer: accepts a DATA_WIDTH word over valid/ready
// and emits it LANES bits per beat, LSB-first or MSB-first, under backpressure.
module piso_serializer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned LANES      = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic                  msb_first,
    output logic [LANES-1:0]      dout,
    output logic                  dout_valid,
    output logic                  dout_last,
    input  logic                  dout_ready
);

    localparam int unsigned BEATS = DATA_WIDTH / LANES;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if ((LANES == 0) || (LANES > DATA_WIDTH) || ((DATA_WIDTH % LANES) != 0)) begin : g_bad_lanes
            $error("piso_serializer: LANES must divide DATA_WIDTH");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  order_q, order_d;

    logic accept;
    logic beat_done;

    assign dout_valid = (state_q == SHIFT);
    assign dout_last  = dout_valid && (cnt_q == '0);
    // dout_ready -> din_ready is combinational so a new word can load on the last beat
    assign din_ready  = ~dout_valid | (dout_last & dout_ready);
    assign accept     = din_valid & din_ready;
    assign beat_done  = dout_valid & dout_ready;

    always_comb begin
        dout = '0;
        if (dout_valid) begin
            if (order_q) begin
                dout = sreg_q[DATA_WIDTH-1 -: LANES];
            end else begin
                dout = sreg_q[LANES-1:0];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        order_d = order_q;
        if (accept) begin
            state_d = SHIFT;
            sreg_d  = din;
            cnt_d   = CNT_W'(BEATS - 1);
            order_d = msb_first;
        end else if (beat_done) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
                if (order_q) begin
                    sreg_d = sreg_q << LANES;
                end else begin
                    sreg_d = sreg_q >> LANES;
                end
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            order_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            order_q <= order_d;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one LANES=1 and one LANES=4 instance
// sharing clock and reset, checked with immediate assertions.
module tb_piso_serializer;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] a_din;
    logic        a_din_valid, a_din_ready, a_msb_first;
    logic [0:0]  a_dout;
    logic        a_dout_valid, a_dout_last, a_dout_ready;

    logic [15:0] b_din;
    logic        b_din_valid, b_din_ready, b_msb_first;
    logic [3:0]  b_dout;
    logic        b_dout_valid, b_dout_last, b_dout_ready;

    piso_serializer #(.DATA_WIDTH(16), .LANES(1)) u_dut1 (
        .clk        (clk),
        .resetn     (resetn),
        .din        (a_din),
        .din_valid  (a_din_valid),
        .din_ready  (a_din_ready),
        .msb_first  (a_msb_first),
        .dout       (a_dout),
        .dout_valid (a_dout_valid),
        .dout_last  (a_dout_last),
        .dout_ready (a_dout_ready)
    );

    piso_serializer #(.DATA_WIDTH(16), .LANES(4)) u_dut4 (
        .clk        (clk),
        .resetn     (resetn),
        .din        (b_din),
        .din_valid  (b_din_valid),
        .din_ready  (b_din_ready),
        .msb_first  (b_msb_first),
        .dout       (b_dout),
        .dout_valid (b_dout_valid),
        .dout_last  (b_dout_last),
        .dout_ready (b_dout_ready)
    );

    int unsigned total  = 0;
    int unsigned passed = 0;

    // A5C3 serialized bit sequences, written out by hand
    int seq_lsb[16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int seq_msb[16] = '{1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1};
    int seq_05[16]  = '{1,0,1,0,0,0,0,0,0,0,0,0,0,0,0,0};
    int b_lsb[4]    = '{4,3,2,1};
    int b_msb[4]    = '{1,2,3,4};
    int b_abcd[4]   = '{4'hD,4'hC,4'hB,4'hA};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // advance one rising edge, then let registered outputs settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        a_din = '0; a_din_valid = 0; a_msb_first = 0; a_dout_ready = 1;
        b_din = '0; b_din_valid = 0; b_msb_first = 0; b_dout_ready = 1;

        // 1: reset then idle
        resetn = 0;
        tick();
        tick();
        chk("rst_valid", 32'(a_dout_valid), 0);
        chk("rst_last", 32'(a_dout_last), 0);
        chk("rst_dout", 32'(a_dout), 0);
        chk("rst_ready", 32'(a_din_ready), 1);
        chk("rst_b_ready", 32'(b_din_ready), 1);
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("idle_valid%0d", i), 32'(a_dout_valid), 0);
            chk($sformatf("idle_dout%0d", i), 32'(a_dout), 0);
            chk($sformatf("idle_ready%0d", i), 32'(a_din_ready), 1);
        end

        // 2: LANES=1 LSB-first
        a_din = 16'hA5C3; a_msb_first = 0; a_din_valid = 1;
        #1 chk("t2_accept_ready", 32'(a_din_ready), 1);
        tick();
        a_din_valid = 0; a_din = 16'h0000; a_msb_first = 1;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("t2_valid%0d", k), 32'(a_dout_valid), 1);
            chk($sformatf("t2_dout%0d", k), 32'(a_dout), 32'(seq_lsb[k]));
            chk($sformatf("t2_last%0d", k), 32'(a_dout_last), (k == 15) ? 1 : 0);
            tick();
        end
        chk("t2_done_valid", 32'(a_dout_valid), 0);
        chk("t2_done_dout", 32'(a_dout), 0);

        // 3: LANES=1 MSB-first
        a_din = 16'hA5C3; a_msb_first = 1; a_din_valid = 1;
        tick();
        a_din_valid = 0; a_msb_first = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("t3_dout%0d", k), 32'(a_dout), 32'(seq_msb[k]));
            chk($sformatf("t3_last%0d", k), 32'(a_dout_last), (k == 15) ? 1 : 0);
            tick();
        end
        chk("t3_done_valid", 32'(a_dout_valid), 0);

        // 4: back-to-back FFFF then 0000, din_valid held high
        a_din = 16'hFFFF; a_msb_first = 0; a_din_valid = 1;
        #1 chk("t4_accept_ready", 32'(a_din_ready), 1);
        tick();
        a_din = 16'h0000;
        for (int k = 0; k < 32; k++) begin
            if (k == 31) a_din_valid = 0;
            #1;
            chk($sformatf("t4_valid%0d", k), 32'(a_dout_valid), 1);
            chk($sformatf("t4_dout%0d", k), 32'(a_dout), (k < 16) ? 1 : 0);
            chk($sformatf("t4_ready%0d", k), 32'(a_din_ready), (k == 15 || k == 31) ? 1 : 0);
            tick();
        end
        chk("t4_done_valid", 32'(a_dout_valid), 0);

        // 5a: LANES=4 LSB-first
        b_din = 16'h1234; b_msb_first = 0; b_din_valid = 1;
        tick();
        b_din_valid = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t5a_dout%0d", k), 32'(b_dout), 32'(b_lsb[k]));
            chk($sformatf("t5a_last%0d", k), 32'(b_dout_last), (k == 3) ? 1 : 0);
            tick();
        end
        chk("t5a_done_valid", 32'(b_dout_valid), 0);

        // 5b: LANES=4 MSB-first, next word accepted on the last beat
        b_din = 16'h1234; b_msb_first = 1; b_din_valid = 1;
        tick();
        b_din_valid = 0;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) begin
                b_din = 16'hABCD; b_msb_first = 0; b_din_valid = 1;
            end
            #1;
            chk($sformatf("t5b_dout%0d", k), 32'(b_dout), 32'(b_msb[k]));
            chk($sformatf("t5b_last%0d", k), 32'(b_dout_last), (k == 3) ? 1 : 0);
            tick();
        end
        b_din_valid = 0; b_din = 16'h0000; b_msb_first = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t5b2_valid%0d", k), 32'(b_dout_valid), 1);
            chk($sformatf("t5b2_dout%0d", k), 32'(b_dout), 32'(b_abcd[k]));
            tick();
        end
        chk("t5b2_done_valid", 32'(b_dout_valid), 0);

        // 5c: stall on beat 2 for three cycles
        b_din = 16'h1234; b_msb_first = 0; b_din_valid = 1;
        tick();
        b_din_valid = 0;
        #1 chk("t5c_beat1", 32'(b_dout), 4);
        tick();
        b_dout_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t5c_hold_dout%0d", i), 32'(b_dout), 3);
            chk($sformatf("t5c_hold_valid%0d", i), 32'(b_dout_valid), 1);
            chk($sformatf("t5c_hold_last%0d", i), 32'(b_dout_last), 0);
            chk($sformatf("t5c_hold_ready%0d", i), 32'(b_din_ready), 0);
            tick();
        end
        b_dout_ready = 1;
        for (int k = 1; k < 4; k++) begin
            #1;
            chk($sformatf("t5c_dout%0d", k), 32'(b_dout), 32'(b_lsb[k]));
            chk($sformatf("t5c_last%0d", k), 32'(b_dout_last), (k == 3) ? 1 : 0);
            tick();
        end
        chk("t5c_done_valid", 32'(b_dout_valid), 0);

        // 6: reset mid-word, then a fresh word
        a_din = 16'hFFFF; a_msb_first = 0; a_din_valid = 1;
        tick();
        a_din_valid = 0;
        for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("t6_pre%0d", k), 32'(a_dout), 1);
            tick();
        end
        #1 chk("t6_beat5", 32'(a_dout_valid), 1);
        resetn = 0;
        tick();
        resetn = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("t6_post_valid%0d", i), 32'(a_dout_valid), 0);
            chk($sformatf("t6_post_dout%0d", i), 32'(a_dout), 0);
            chk($sformatf("t6_post_ready%0d", i), 32'(a_din_ready), 1);
            tick();
        end
        a_din = 16'h0005; a_msb_first = 0; a_din_valid = 1;
        tick();
        a_din_valid = 0;
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("t6_dout%0d", k), 32'(a_dout), 32'(seq_05[k]));
            chk($sformatf("t6_last%0d", k), 32'(a_dout_last), (k == 15) ? 1 : 0);
            tick();
        end
        chk("t6_done_valid", 32'(a_dout_valid), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
